// File: rtl/mux21_pkg.sv
// Shared encodings for the 2:1 mux and its select arbiter.
// Used by this block and by the mux21 benches.
package mux21_pkg;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] GNT_A = 2'b01;
    localparam logic [1:0] GNT_B = 2'b10;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Select value that hands the mux to the requester opposite to sel.
    function automatic logic other_sel(input logic sel);
        return (sel == SEL_A) ? SEL_B : SEL_A;
    endfunction

endpackage : mux21_pkg

// File: rtl/mux21_sel_arbiter_if.sv
// Requester/downstream handshake bundle around the mux21 select arbiter.
// The master side drives requests and ready; the slave side is the arbiter.
interface mux21_sel_arbiter_if #(
    parameter int unsigned MAX_BURST = 4
);
    localparam int unsigned CNT_W = $clog2(MAX_BURST);

    logic             req_a;
    logic             req_b;
    logic             last_a;
    logic             last_b;
    logic             out_ready;
    logic             s;
    logic             gnt_a;
    logic             gnt_b;
    logic             out_valid;
    logic [CNT_W-1:0] beat_cnt;

    modport master (
        output req_a,
        output req_b,
        output last_a,
        output last_b,
        output out_ready,
        input  s,
        input  gnt_a,
        input  gnt_b,
        input  out_valid,
        input  beat_cnt
    );

    modport slave (
        input  req_a,
        input  req_b,
        input  last_a,
        input  last_b,
        input  out_ready,
        output s,
        output gnt_a,
        output gnt_b,
        output out_valid,
        output beat_cnt
    );

endinterface : mux21_sel_arbiter_if

// File: rtl/mux21_sel_arbiter_beat_counter.sv
// Per-grant beat counter: clear wins over increment; tc_c flags the
// last beat allowed before the fairness cap forces re-arbitration.
module mux21_sel_arbiter_beat_counter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           inc,
    output logic [$clog2(MAX_BURST)-1:0]   cnt,
    output logic                           tc_c
);
    localparam int unsigned CNT_W = $clog2(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign tc_c = (cnt_q == CNT_MAX);

endmodule : mux21_sel_arbiter_beat_counter

// File: rtl/mux21_sel_arbiter.sv
// Round-robin select arbiter for mux21: burst lock per grant, MAX_BURST
// fairness cap, and a select that only moves on grant entry or switch.
module mux21_sel_arbiter
    import mux21_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    mux21_sel_arbiter_if.slave       bus
);
    localparam int unsigned CNT_W = $clog2(MAX_BURST);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             s_q;
    logic             s_d;
    logic             gnt_a_q;
    logic             gnt_a_d;
    logic             gnt_b_q;
    logic             gnt_b_d;
    logic             prio_q;
    logic             prio_d;

    logic             out_valid_c;
    logic             xfer_c;
    logic             cnt_clr_c;
    logic             cnt_inc_c;
    logic             cnt_tc_c;
    logic [CNT_W-1:0] beat_cnt;

    // Valid comes only from registered grants and live requests; ready never feeds it.
    assign out_valid_c = (gnt_a_q & bus.req_a) | (gnt_b_q & bus.req_b);
    assign xfer_c      = out_valid_c & bus.out_ready;

    mux21_sel_arbiter_beat_counter #(
        .MAX_BURST (MAX_BURST)
    ) u_beat_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr_c),
        .inc  (cnt_inc_c),
        .cnt  (beat_cnt),
        .tc_c (cnt_tc_c)
    );

    // Next-state, priority and counter control.
    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        cnt_clr_c = 1'b0;
        cnt_inc_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_a && (!bus.req_b || (prio_q == SEL_A))) begin
                    state_d = GNT_A;
                end else if (bus.req_b) begin
                    state_d = GNT_B;
                end
            end

            GNT_A: begin
                if (xfer_c) begin
                    if (bus.last_a || cnt_tc_c) begin
                        prio_d    = other_sel(SEL_A);
                        cnt_clr_c = 1'b1;
                        if (bus.req_b) begin
                            state_d = GNT_B;
                        end else if (!bus.last_a && bus.req_a) begin
                            state_d = GNT_A;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_inc_c = 1'b1;
                    end
                end
            end

            GNT_B: begin
                if (xfer_c) begin
                    if (bus.last_b || cnt_tc_c) begin
                        prio_d    = other_sel(SEL_B);
                        cnt_clr_c = 1'b1;
                        if (bus.req_a) begin
                            state_d = GNT_A;
                        end else if (!bus.last_b && bus.req_b) begin
                            state_d = GNT_B;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_inc_c = 1'b1;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                cnt_clr_c = 1'b1;
            end
        endcase
    end

    // Registered outputs decoded from the next state; select holds while idle.
    always_comb begin
        gnt_a_d = (state_d == GNT_A);
        gnt_b_d = (state_d == GNT_B);
        s_d     = s_q;
        if (state_d == GNT_A) begin
            s_d = SEL_A;
        end else if (state_d == GNT_B) begin
            s_d = SEL_B;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= SEL_A;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            prio_q  <= SEL_A;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            gnt_a_q <= gnt_a_d;
            gnt_b_q <= gnt_b_d;
            prio_q  <= prio_d;
        end
    end

    assign bus.s         = s_q;
    assign bus.gnt_a     = gnt_a_q;
    assign bus.gnt_b     = gnt_b_q;
    assign bus.out_valid = out_valid_c;
    assign bus.beat_cnt  = beat_cnt;

endmodule : mux21_sel_arbiter

// File: doc/mux21_sel_arbiter.md
Name: mux21_sel_arbiter

Overview:
- Upstream control stage for the 2:1 mux (`mux21`, y = s ? b : a).
- Arbitrates between two bursting requesters, A and B, and drives the mux select `s`.
- Round-robin between A and B, with burst lock and a MAX_BURST fairness cap.
- Downstream sees a single valid/ready stream; data itself passes through `mux21` outside this block.

Parameters:
- MAX_BURST, 4, maximum beats one requester may transfer per grant before a forced re-arbitration (legal range 2..256).
- CNT_W, $clog2(MAX_BURST), width of beat_cnt.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- req_a  input  1  requester A has a beat pending.
- req_b  input  1  requester B has a beat pending.
- last_a  input  1  current A beat ends A's burst; qualified by transfer.
- last_b  input  1  current B beat ends B's burst; qualified by transfer.
- out_ready  input  1  downstream accepts the beat.
- s  output  1  mux select: 0 = A, 1 = B; registered.
- gnt_a  output  1  A owns the mux; registered.
- gnt_b  output  1  B owns the mux; registered.
- out_valid  output  1  valid beat at mux output; equals (gnt_a & req_a) | (gnt_b & req_b).
- beat_cnt  output  CNT_W  beats transferred in current grant; registered.

Behaviour:
- Only one clock and one reset: clk, rst. rst is synchronous and active-high.
- Reset values: state=IDLE, s=0, gnt_a=0, gnt_b=0, out_valid=0, beat_cnt=0, prio=A (A preferred on tie).
- Transfer (xfer) = out_valid & out_ready. All state updates happen on the clk rising edge.
- States:
  - IDLE: no grant.
  - GNT_A: gnt_a=1, s=0.
  - GNT_B: gnt_b=1, s=1.
  - Grants are one-hot or zero; never both.
- IDLE transitions:
  - Only req_a → GNT_A.
  - Only req_b → GNT_B.
  - Both → the state selected by prio.
  - Neither → stay IDLE.
  - Latency req→gnt is 1 cycle.
- GNT_X, no xfer: hold state, s and beat_cnt.
  - Dropping req_x without last_x does not release the grant; out_valid goes low and the grant is kept.
- GNT_X, xfer with burst_end, where burst_end = last_x | (beat_cnt == MAX_BURST-1):
  - prio ← other requester.
  - beat_cnt ← 0.
  - If the other requester is active → GNT_other directly (no bubble; s toggles in the same edge).
  - Else if the end was forced by the cap only and req_x is active → stay GNT_X.
  - Else → IDLE.
- GNT_X, xfer without burst_end: beat_cnt ← beat_cnt+1; stay.
- s changes only on the edge entering GNT_A/GNT_B from IDLE or on a switch. It is stable for the whole grant, so `mux21` never glitches mid-beat.
- out_valid is combinational from registered grant and live req. It must not depend on out_ready (no combinational ready→valid path).
- beat_cnt never exceeds MAX_BURST-1. Wrap to 0 occurs only via burst_end.
- last_x with no xfer has no effect.
- rst asserted mid-burst: the next edge forces reset values regardless of other inputs. No partial beat is counted.
- rst has priority over all transitions.

Decomposition:
- Shared package mux21_pkg:
  - state encoding: IDLE=2'b00, GNT_A=2'b01, GNT_B=2'b10.
  - select constants: SEL_A=1'b0, SEL_B=1'b1.
  - Reused by `mux21` benches and this block.
- Optional sub-module beat_counter: CNT_W-bit counter with clear, increment and terminal-count flag. It is natural because the cap logic is the only arithmetic.
- The FSM stays in the top.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with req_a=req_b=1 → s=0, gnt_a=gnt_b=0, out_valid=0, beat_cnt=0. After release, gnt_a=1 one cycle later.
2. Single burst: req_a=1, out_ready=1, last_a on the 3rd beat, req_b=0 → beat_cnt 0,1,2. IDLE on the next edge; gnt_a=0 afterwards.
3. Back-to-back switch: A and B both requesting, last_a on A's 2nd beat → the next cycle has gnt_b=1, s=1, beat_cnt=0, with no idle cycle. The next tie is won by A.
4. Fairness cap: MAX_BURST=4, req_a and req_b held, last never asserted → A transfers exactly 4 beats, then B transfers 4, alternating. s toggles every 4 xfers.
5. Backpressure: GNT_B, out_ready=0 for 5 cycles → s=1, beat_cnt and state frozen, out_valid=1 throughout. last_b during the stall is ignored.
6. Mid-burst reset: GNT_A with beat_cnt=2, assert rst for one cycle → all outputs return to reset values on that edge. A tie afterwards goes to A.
